vga_text_render: RTL and testbench

Display-side reader for the 8×8-cell text buffer: generates VESA 1280×1024@60 raster timing and scans the buffer read port (addr_read / char_read) cell by cell. Each character code goes through an external 8×8 font ROM to produce the pixel colour, and a blinking block cursor is overlaid. It sits between the text buffer's read port and the VGA pins, and shares `clk` with the buffer write logic.

---
 rtl/vga_text_render.sv | 147 ++++++++++++++
 tb/tb_vga_text_render.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/vga_text_render.sv
// rtl/vga_text_render.sv - VESA raster generator and 8x8 text-cell renderer with blinking cursor

module vga_text_render #(
  parameter int h_disp  = 1280,
  parameter int h_front = 48,
  parameter int h_sync  = 112,
  parameter int h_back  = 248,
  parameter int v_disp  = 1024,
  parameter int v_front = 1,
  parameter int v_sync  = 3,
  parameter int v_back  = 38,
  parameter logic [11:0] fg_color = 12'hFFF,
  parameter logic [11:0] bg_color = 12'h000,
  localparam int x_limit    = h_disp / 8,
  localparam int y_limit    = v_disp / 8,
  localparam int addr_width = $clog2(x_limit * y_limit)
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [addr_width-1:0] addr_read,
  input  logic [7:0]            char_read,
  output logic [10:0]           font_addr,
  input  logic [7:0]            font_row,
  input  logic [7:0]            cursor_x,
  input  logic [6:0]            cursor_y,
  output logic                  vga_hsync,
  output logic                  vga_vsync,
  output logic [11:0]           vga_rgb,
  output logic                  frame_start
);

  localparam int h_total = h_disp + h_front + h_sync + h_back;
  localparam int v_total = v_disp + v_front + v_sync + v_back;
  localparam int hw = $clog2(h_total);
  localparam int vw = $clog2(v_total);

  localparam logic [hw-1:0] h_last   = hw'(h_total - 1);
  localparam logic [hw-1:0] h_act    = hw'(h_disp);
  localparam logic [hw-1:0] hs_start = hw'(h_disp + h_front);
  localparam logic [hw-1:0] hs_end   = hw'(h_disp + h_front + h_sync);
  localparam logic [vw-1:0] v_last   = vw'(v_total - 1);
  localparam logic [vw-1:0] v_act    = vw'(v_disp);
  localparam logic [vw-1:0] vs_start = vw'(v_disp + v_front);
  localparam logic [vw-1:0] vs_end   = vw'(v_disp + v_front + v_sync);

  logic [hw-1:0] h_cnt, h_cnt_d1, h_cnt_d2;
  logic [vw-1:0] v_cnt, v_cnt_d1, v_cnt_d2;
  logic          active0, hs0, vs0;
  logic          active_d1, hs_d1, vs_d1, valid_d1;
  logic          active_d2, hs_d2, vs_d2, valid_d2;
  logic [5:0]    blink_cnt;
  logic          blink_on, cursor_cell, pix_bit, frame_end;

  // Stage 0 raster position: h wraps every line, v advances on h wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == h_last) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == v_last) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign active0 = (h_cnt < h_act) && (v_cnt < v_act);
  assign hs0     = (h_cnt >= hs_start) && (h_cnt < hs_end);
  assign vs0     = (v_cnt >= vs_start) && (v_cnt < vs_end);

  // Cell address into the text buffer; parked at 0 during blanking
  assign addr_read = active0
    ? addr_width'(32'(v_cnt >> 3) * x_limit + 32'(h_cnt >> 3))
    : '0;

  // Stage 1: character code is back from the buffer, look up its glyph row
  assign font_addr = {char_read, v_cnt_d1[2:0]};

  // Pipeline registers; valid marks stages holding a real raster position,
  // so cleared-by-reset contents never produce a frame_start pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt_d1  <= '0;
      v_cnt_d1  <= '0;
      active_d1 <= 1'b0;
      hs_d1     <= 1'b0;
      vs_d1     <= 1'b0;
      valid_d1  <= 1'b0;
      h_cnt_d2  <= '0;
      v_cnt_d2  <= '0;
      active_d2 <= 1'b0;
      hs_d2     <= 1'b0;
      vs_d2     <= 1'b0;
      valid_d2  <= 1'b0;
    end else begin
      h_cnt_d1  <= h_cnt;
      v_cnt_d1  <= v_cnt;
      active_d1 <= active0;
      hs_d1     <= hs0;
      vs_d1     <= vs0;
      valid_d1  <= 1'b1;
      h_cnt_d2  <= h_cnt_d1;
      v_cnt_d2  <= v_cnt_d1;
      active_d2 <= active_d1;
      hs_d2     <= hs_d1;
      vs_d2     <= vs_d1;
      valid_d2  <= valid_d1;
    end
  end

  // Stage 2: glyph bit select (bit 7 is leftmost) and cursor inversion.
  // Out-of-range cursor coordinates are rejected explicitly so a cursor
  // column beyond the visible width cannot match a blanking-region cell.
  assign blink_on    = ~blink_cnt[5];
  assign cursor_cell = (32'(h_cnt_d2 >> 3) == 32'(cursor_x)) &&
                       (32'(v_cnt_d2 >> 3) == 32'(cursor_y)) &&
                       (32'(cursor_x) < x_limit) && (32'(cursor_y) < y_limit) &&
                       blink_on;
  assign pix_bit     = font_row[~h_cnt_d2[2:0]] ^ cursor_cell;
  assign frame_end   = valid_d2 && (h_cnt_d2 == h_last) && (v_cnt_d2 == v_last);

  // Frame counter steps on the last pixel of a frame, so frame N of the
  // raster is drawn with blink_cnt == N mod 64 from its first pixel on
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt <= '0;
    end else if (frame_end) begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Stage 3: registered pins, all fed from stage 2 so they stay aligned
  always_ff @(posedge clk) begin
    if (reset) begin
      vga_rgb     <= '0;
      vga_hsync   <= 1'b0;
      vga_vsync   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      vga_rgb     <= active_d2 ? (pix_bit ? fg_color : bg_color) : 12'h000;
      vga_hsync   <= hs_d2;
      vga_vsync   <= vs_d2;
      frame_start <= valid_d2 && (h_cnt_d2 == '0) && (v_cnt_d2 == '0);
    end
  end

endmodule

// File: tb/tb_vga_text_render.sv
// tb/tb_vga_text_render.sv - directed self-checking bench for vga_text_render

module tb_vga_text_render;

  logic        clk = 1'b0;
  logic        reset;
  int          cyc;
  int          checks = 0;
  int          errors = 0;

  // Full VESA timing instance
  logic [14:0] full_addr;
  logic [7:0]  full_char;
  logic [10:0] full_fa;
  logic [7:0]  full_font;
  logic [7:0]  full_cx;
  logic [6:0]  full_cy;
  logic        full_hs, full_vs, full_fs;
  logic [11:0] full_rgb;

  // Shrunken timing instance: 24x32 visible, 28x35 total, 980-cycle frame
  logic [3:0]  small_addr;
  logic [7:0]  small_char;
  logic [10:0] small_fa;
  logic [7:0]  small_font;
  logic [7:0]  small_cx;
  logic [6:0]  small_cy;
  logic        small_hs, small_vs, small_fs;
  logic [11:0] small_rgb;
  logic        small_mode;

  always #5 clk = ~clk;

  vga_text_render u_full (
    .clk(clk), .reset(reset),
    .addr_read(full_addr), .char_read(full_char),
    .font_addr(full_fa), .font_row(full_font),
    .cursor_x(full_cx), .cursor_y(full_cy),
    .vga_hsync(full_hs), .vga_vsync(full_vs),
    .vga_rgb(full_rgb), .frame_start(full_fs)
  );

  vga_text_render #(
    .h_disp(24), .h_front(1), .h_sync(2), .h_back(1),
    .v_disp(32), .v_front(1), .v_sync(1), .v_back(1)
  ) u_small (
    .clk(clk), .reset(reset),
    .addr_read(small_addr), .char_read(small_char),
    .font_addr(small_fa), .font_row(small_font),
    .cursor_x(small_cx), .cursor_y(small_cy),
    .vga_hsync(small_hs), .vga_vsync(small_vs),
    .vga_rgb(small_rgb), .frame_start(small_fs)
  );

  // One-cycle text buffer and font ROM models
  always @(posedge clk) begin
    full_char  <= (full_addr == 15'd1) ? 8'h41 : 8'h00;
    full_font  <= (full_fa == 11'h208) ? 8'hA5 : 8'h00;
    small_char <= 8'h00;
    small_font <= small_mode ? 8'h80 : 8'h00;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " full_rgb"}, full_rgb, 0);
    check({tag, " full_hs"}, full_hs, 0);
    check({tag, " full_vs"}, full_vs, 0);
    check({tag, " full_fs"}, full_fs, 0);
    check({tag, " small_rgb"}, small_rgb, 0);
    check({tag, " small_hs"}, small_hs, 0);
    check({tag, " small_vs"}, small_vs, 0);
    check({tag, " small_fs"}, small_fs, 0);
  endtask

  localparam int last_cyc = 65 * 980 + 5;

  initial begin
    logic [7:0] glyph_a5;
    int p, ph, pv, pf, s, sh, sv, s1;
    logic exp_bit, exp_act;
    glyph_a5   = 8'hA5;
    reset      = 1'b1;
    small_mode = 1'b0;
    full_cx    = 8'd200;
    full_cy    = 7'd0;
    small_cx   = 8'd2;
    small_cy   = 7'd3;
    cyc        = 0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");

    reset = 1'b0;
    cyc   = 0;
    for (int c = 1; c <= last_cyc; c++) begin
      step();
      p = cyc - 3;

      // Small instance outputs
      if (p < 0) begin
        check_quiet("startup");
      end else begin
        ph = p % 28;
        pv = (p / 28) % 35;
        pf = p / 980;
        exp_act = (ph < 24) && (pv < 32);
        exp_bit = ((pf == 40) && (ph % 8 == 0)) ^
                  ((ph / 8 == 2) && (pv / 8 == 3) && ((pf % 64) < 32));
        check("small_rgb", small_rgb, (exp_act && exp_bit) ? 12'hFFF : 12'h000);
        check("small_hs", small_hs, (ph >= 25) && (ph < 27));
        check("small_vs", small_vs, pv == 33);
        check("small_fs", small_fs, (ph == 0) && (pv == 0));
      end
      s  = cyc;
      sh = s % 28;
      sv = (s / 28) % 35;
      check("small_addr", small_addr, (sh < 24 && sv < 32) ? (sv / 8) * 3 + sh / 8 : 0);
      s1 = cyc - 1;
      check("small_font_addr", small_fa, ((s1 / 28) % 35) % 8);

      // Full instance over the first line
      if (cyc < 1688) begin
        check("full_addr", full_addr, (cyc < 1280) ? cyc / 8 : 0);
        check("full_font_addr", full_fa, (s1 >= 8 && s1 < 16) ? 11'h208 : 11'h000);
      end
      if (p >= 0 && p < 1688) begin
        exp_bit = (p >= 8 && p < 16) ? glyph_a5[7 - (p - 8)] : 1'b0;
        check("full_rgb", full_rgb, exp_bit ? 12'hFFF : 12'h000);
        check("full_hs", full_hs, (p >= 1328) && (p < 1440));
        check("full_vs", full_vs, 0);
        check("full_fs", full_fs, p == 0);
      end

      // Glyph ROM returns 0x80 for the reads feeding output frame 40
      small_mode = (cyc >= 39144) && (cyc < 40124);
    end

    // Reset in the middle of a frame (small raster at h=10, v=26)
    for (int i = 0; i < 1000 && (cyc % 980) != 738; i++) step();
    check("reset_point", cyc % 980, 738);
    reset = 1'b1;
    repeat (4) begin
      step();
      check_quiet("in_reset");
    end
    reset = 1'b0;
    cyc   = 0;
    step();
    check_quiet("post_reset1");
    step();
    check_quiet("post_reset2");
    step();
    check("post_reset3 full_fs", full_fs, 1);
    check("post_reset3 small_fs", small_fs, 1);
    check("post_reset3 full_rgb", full_rgb, 0);
    check("post_reset3 small_rgb", small_rgb, 0);
    check("post_reset3 small_hs", small_hs, 0);
    step();
    check("post_reset4 full_fs", full_fs, 0);
    check("post_reset4 small_fs", small_fs, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
